csr_trap_ctrl: RTL and testbench

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_pkg.sv | 23 ++
 rtl/csr_trap_ctrl.sv | 146 ++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// CSR addresses, mstatus bit positions and the default interrupt cause.
package csr_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SAVE_EPC    = 3'd1,
        SAVE_CAUSE  = 3'd2,
        SAVE_STATUS = 3'd3,
        REDIRECT    = 3'd4,
        MRET        = 3'd5
    } trap_state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    localparam logic [31:0] IRQ_CAUSE_DEFAULT = 32'h8000_000B;

endpackage

// File: rtl/csr_trap_ctrl.sv
// Trap / MRET sequencer. Owns the single CSR-file write port: in IDLE it
// forwards pipeline CSR writes; on a trap it serialises the mepc, mcause
// and mstatus updates over three cycles and then redirects fetch to mtvec.
// MRET restores MIE from MPIE and redirects to mepc in one cycle.
// The pipeline is held via stall_o for the whole sequence.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] IRQ_CAUSE = XLEN'(csr_pkg::IRQ_CAUSE_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            irq_i,
    input  logic            exc_i,
    input  logic [XLEN-1:0] exc_cause_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            instr_csr_we_i,
    input  logic [11:0]     instr_csr_addr_i,
    input  logic [XLEN-1:0] instr_csr_wdata_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            stall_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    trap_state_t     state;
    trap_state_t     state_next;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] cause;
    logic            idle;
    logic            trap_take;
    logic [XLEN-1:0] status_trap;
    logic [XLEN-1:0] status_mret;

    // Trap decision and the two mstatus rewrite values.
    // Trap entry: MPIE <= MIE, MIE <= 0. Return: MIE <= MPIE, MPIE <= 1.
    always_comb begin
        idle      = (state == IDLE);
        trap_take = idle & (exc_i | (irq_i & mstatus_i[MIE_BIT]));

        status_trap           = mstatus_i;
        status_trap[MPIE_BIT] = mstatus_i[MIE_BIT];
        status_trap[MIE_BIT]  = 1'b0;

        status_mret           = mstatus_i;
        status_mret[MIE_BIT]  = mstatus_i[MPIE_BIT];
        status_mret[MPIE_BIT] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture PC and cause at the moment the trap is accepted; exceptions win over interrupts.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc   <= '0;
            cause <= '0;
        end else if (trap_take) begin
            epc   <= pc_i;
            cause <= exc_i ? exc_cause_i : IRQ_CAUSE;
        end
    end

    // Next state and all outputs. Reset forces every output low so that a
    // sequence interrupted by rst issues no further write or redirect.
    always_comb begin
        state_next    = state;
        csr_we_o      = 1'b0;
        csr_addr_o    = '0;
        csr_wdata_o   = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        stall_o       = ~idle | trap_take | mret_i;

        case (state)
            IDLE: begin
                if (trap_take) begin
                    state_next = SAVE_EPC;
                end else if (mret_i) begin
                    state_next = MRET;
                end else begin
                    csr_we_o    = instr_csr_we_i;
                    csr_addr_o  = instr_csr_addr_i;
                    csr_wdata_o = instr_csr_wdata_i;
                end
            end
            SAVE_EPC: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MEPC;
                csr_wdata_o = epc;
                state_next  = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MCAUSE;
                csr_wdata_o = cause;
                state_next  = SAVE_STATUS;
            end
            SAVE_STATUS: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MSTATUS;
                csr_wdata_o = status_trap;
                state_next  = REDIRECT;
            end
            REDIRECT: begin
                redirect_o    = 1'b1;
                redirect_pc_o = mtvec_i & ~XLEN'(3);
                state_next    = IDLE;
            end
            MRET: begin
                csr_we_o      = 1'b1;
                csr_addr_o    = CSR_MSTATUS;
                csr_wdata_o   = status_mret;
                redirect_o    = 1'b1;
                redirect_pc_o = mepc_i;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (rst) begin
            csr_we_o      = 1'b0;
            csr_addr_o    = '0;
            csr_wdata_o   = '0;
            redirect_o    = 1'b0;
            redirect_pc_o = '0;
            stall_o       = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed trap/MRET/reset scenarios followed by
// random traffic, all checked cycle by cycle against a model that keeps a
// queue of the CSR writes and redirects still owed by an accepted trap.
module tb_csr_trap_ctrl;

    localparam int XLEN = 32;

    localparam logic [2:0] ACT_EPC    = 3'd1;
    localparam logic [2:0] ACT_CAUSE  = 3'd2;
    localparam logic [2:0] ACT_STATUS = 3'd3;
    localparam logic [2:0] ACT_JUMP   = 3'd4;
    localparam logic [2:0] ACT_MRET   = 3'd5;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] pc_i;
    logic            irq_i;
    logic            exc_i;
    logic [XLEN-1:0] exc_cause_i;
    logic            mret_i;
    logic [XLEN-1:0] mstatus_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;
    logic            instr_csr_we_i;
    logic [11:0]     instr_csr_addr_i;
    logic [XLEN-1:0] instr_csr_wdata_i;
    logic            csr_we_o;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic            stall_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;

    int tests_run;
    int tests_failed;

    // Owed actions of the trap or MRET in progress, oldest first.
    logic [2:0]  exp_q[$];
    logic [31:0] saved_pc;
    logic [31:0] saved_cause;

    csr_trap_ctrl #(.XLEN(XLEN), .IRQ_CAUSE(32'h8000_000B)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_i              (pc_i),
        .irq_i             (irq_i),
        .exc_i             (exc_i),
        .exc_cause_i       (exc_cause_i),
        .mret_i            (mret_i),
        .mstatus_i         (mstatus_i),
        .mtvec_i           (mtvec_i),
        .mepc_i            (mepc_i),
        .instr_csr_we_i    (instr_csr_we_i),
        .instr_csr_addr_i  (instr_csr_addr_i),
        .instr_csr_wdata_i (instr_csr_wdata_i),
        .csr_we_o          (csr_we_o),
        .csr_addr_o        (csr_addr_o),
        .csr_wdata_o       (csr_wdata_o),
        .stall_o           (stall_o),
        .redirect_o        (redirect_o),
        .redirect_pc_o     (redirect_pc_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drop every strobe; CSR values are left as they are.
    task automatic quiet_inputs();
        rst            = 1'b0;
        irq_i          = 1'b0;
        exc_i          = 1'b0;
        mret_i         = 1'b0;
        instr_csr_we_i = 1'b0;
    endtask

    // Let inputs settle, compare all outputs with the model, then advance
    // the model as the coming rising edge will.
    task automatic settle();
        logic        e_we, e_stall, e_rd, take;
        logic [11:0] e_addr;
        logic [31:0] e_wd, e_rpc, m;
        logic [2:0]  act;
        #1;
        e_we = 1'b0; e_addr = '0; e_wd = '0; e_stall = 1'b0; e_rd = 1'b0; e_rpc = '0;
        m    = mstatus_i;
        take = exc_i | (irq_i & m[3]);
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            act     = exp_q.pop_front();
            e_stall = 1'b1;
            case (act)
                ACT_EPC:    begin e_we = 1'b1; e_addr = 12'h341; e_wd = saved_pc; end
                ACT_CAUSE:  begin e_we = 1'b1; e_addr = 12'h342; e_wd = saved_cause; end
                ACT_STATUS: begin
                    e_we = 1'b1; e_addr = 12'h300;
                    e_wd = (m & ~32'h88) | (m[3] ? 32'h80 : 32'h0);
                end
                ACT_JUMP:   begin e_rd = 1'b1; e_rpc = mtvec_i - (mtvec_i % 4); end
                default:    begin
                    e_we = 1'b1; e_addr = 12'h300;
                    e_wd = (m & ~32'h8) | (m[7] ? 32'h8 : 32'h0) | 32'h80;
                    e_rd = 1'b1; e_rpc = mepc_i;
                end
            endcase
        end else if (take) begin
            e_stall     = 1'b1;
            saved_pc    = pc_i;
            saved_cause = exc_i ? exc_cause_i : 32'h8000_000B;
            exp_q       = '{ACT_EPC, ACT_CAUSE, ACT_STATUS, ACT_JUMP};
        end else if (mret_i) begin
            e_stall = 1'b1;
            exp_q.push_back(ACT_MRET);
        end else begin
            e_we   = instr_csr_we_i;
            e_addr = instr_csr_addr_i;
            e_wd   = instr_csr_wdata_i;
        end
        check("csr_we",      32'(csr_we_o),      32'(e_we));
        check("csr_addr",    32'(csr_addr_o),    32'(e_addr));
        check("csr_wdata",   csr_wdata_o,        e_wd);
        check("stall",       32'(stall_o),       32'(e_stall));
        check("redirect",    32'(redirect_o),    32'(e_rd));
        check("redirect_pc", redirect_pc_o,      e_rpc);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Stimulus
    initial begin
        tests_run = 0; tests_failed = 0;
        saved_pc = '0; saved_cause = '0;
        pc_i = '0; exc_cause_i = '0; mstatus_i = '0; mtvec_i = '0; mepc_i = '0;
        instr_csr_addr_i = '0; instr_csr_wdata_i = '0;
        quiet_inputs();
        rst = 1'b1;
        @(negedge clk);

        // Reset: everything low.
        for (int i = 0; i < 2; i++) begin
            settle(); next_cycle();
        end
        check("reset_stall", 32'(stall_o), 32'h0);
        rst = 1'b0;
        settle(); next_cycle();

        // Interrupt with MIE=1: three writes then redirect to aligned mtvec.
        irq_i = 1'b1; mstatus_i = 32'h8; pc_i = 32'h100; mtvec_i = 32'h201;
        settle();
        check("irq_n_no_write", 32'(csr_we_o), 32'h0);
        next_cycle(); irq_i = 1'b0;
        settle();
        check("irq_mepc_addr", 32'(csr_addr_o), 32'h341);
        check("irq_mepc_data", csr_wdata_o, 32'h100);
        next_cycle(); settle();
        check("irq_mcause_data", csr_wdata_o, 32'h8000_000B);
        next_cycle(); settle();
        check("irq_mstatus_data", csr_wdata_o, 32'h80);
        next_cycle(); settle();
        check("irq_redirect_pc", redirect_pc_o, 32'h200);
        next_cycle(); settle(); next_cycle();

        // Exception and interrupt together: exception cause wins, stall N..N+4.
        exc_i = 1'b1; exc_cause_i = 32'h2; irq_i = 1'b1; mstatus_i = 32'h8; pc_i = 32'h3c;
        settle();
        check("exc_stall_n", 32'(stall_o), 32'h1);
        next_cycle(); quiet_inputs();
        for (int k = 1; k <= 4; k++) begin
            settle();
            check("exc_stall_hold", 32'(stall_o), 32'h1);
            if (k == 2) check("exc_mcause_data", csr_wdata_o, 32'h2);
            next_cycle();
        end
        settle(); next_cycle();

        // Interrupt masked by MIE=0: instruction write passes through.
        irq_i = 1'b1; mstatus_i = 32'h0;
        instr_csr_we_i = 1'b1; instr_csr_addr_i = 12'h305; instr_csr_wdata_i = 32'h400;
        settle();
        check("masked_we",   32'(csr_we_o), 32'h1);
        check("masked_addr", 32'(csr_addr_o), 32'h305);
        check("masked_data", csr_wdata_o, 32'h400);
        next_cycle(); quiet_inputs();

        // MRET: mstatus 80 -> 88, redirect to mepc the following cycle.
        mret_i = 1'b1; mepc_i = 32'h104; mstatus_i = 32'h80;
        settle();
        check("mret_n_no_write", 32'(csr_we_o), 32'h0);
        next_cycle(); mret_i = 1'b0;
        settle();
        check("mret_status_data", csr_wdata_o, 32'h88);
        check("mret_redirect_pc", redirect_pc_o, 32'h104);
        next_cycle(); settle(); next_cycle();

        // Reset in the middle of a trap sequence.
        irq_i = 1'b1; mstatus_i = 32'h8; pc_i = 32'h500;
        settle(); next_cycle(); irq_i = 1'b0;
        settle(); next_cycle();
        rst = 1'b1;
        settle();
        check("rst_mid_we", 32'(csr_we_o), 32'h0);
        next_cycle(); rst = 1'b0;
        instr_csr_we_i = 1'b1; instr_csr_addr_i = 12'h305; instr_csr_wdata_i = 32'h77;
        settle();
        check("rst_mid_pass_we", 32'(csr_we_o), 32'h1);
        check("rst_mid_no_redirect", 32'(redirect_o), 32'h0);
        next_cycle(); quiet_inputs();
        for (int k = 0; k < 3; k++) begin
            settle(); next_cycle();
        end

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            rst               = ($urandom_range(0, 59) == 0);
            irq_i             = ($urandom_range(0, 3) == 0);
            exc_i             = ($urandom_range(0, 9) == 0);
            mret_i            = ($urandom_range(0, 9) == 0);
            exc_cause_i       = $urandom_range(0, 15);
            pc_i              = $urandom;
            mstatus_i         = $urandom;
            mtvec_i           = $urandom;
            mepc_i            = $urandom;
            instr_csr_we_i    = $urandom_range(0, 1);
            instr_csr_addr_i  = 12'($urandom);
            instr_csr_wdata_i = $urandom;
            settle(); next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
